// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared defaults and width helpers for the IIR decimating output stage
package iir_pkg;

  localparam int DEF_BITWIDTH   = 32;
  localparam int DEF_LOG2R      = 2;
  localparam int DEF_OUT_WIDTH  = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  // Holds the sum of 2^log2r samples of bitwidth bits without overflow.
  function automatic int acc_width(input int bitwidth, input int log2r);
    return bitwidth + log2r;
  endfunction

  // Round-half-up offset added before the divide-by-R shift.
  function automatic int round_offset(input int log2r);
    if (log2r == 0) begin
      return 0;
    end
    return 1 << (log2r - 1);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous circular buffer for decimated output samples
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   s_tvalid/s_tdata : push request and data; accepted when not full or when popping
//   m_tready         : pop request; honoured only when not empty
//   m_tdata          : head entry (0 while empty)
//   full, empty      : occupancy flags
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_tvalid,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr, rd;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // A pop frees the slot in the same cycle, so a full buffer can still take
  // a push when it is being drained. An empty buffer never pops, so there is
  // no same-cycle bypass from s_tdata to m_tdata.
  assign rd = m_tready && !empty;
  assign wr = s_tvalid && (!full || rd);

  assign m_tdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr) begin
      mem_d[wr_ptr_q] = s_tdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr && !rd) begin
      cnt_d = cnt_q + 1'b1;
    end else if (rd && !wr) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/iir_decim_out.sv
// rtl/iir_decim_out.sv - block-average decimator with rounding, optional clamp and output buffer
// Optional feature macro: IIR_DECIM_SAT_EN (clamp to OUT_WIDTH range; otherwise wrap).
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   x_valid, x       : filter output sample in (signed BITWIDTH)
//   y_valid, y_ready : output handshake, y holds the FIFO head (signed OUT_WIDTH)
//   y                : rounded average of each block of 2^LOG2R samples
//   overflow         : sticky, a result was dropped because the buffer was full
//   sat_hit          : sticky, a result was clamped (always 0 without the macro)
module iir_decim_out
  import iir_pkg::*;
#(
  parameter int BITWIDTH   = DEF_BITWIDTH,
  parameter int LOG2R      = DEF_LOG2R,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        x_valid,
  input  logic signed [BITWIDTH-1:0]  x,
  output logic                        y_valid,
  input  logic                        y_ready,
  output logic signed [OUT_WIDTH-1:0] y,
  output logic                        overflow,
  output logic                        sat_hit
);

  localparam int AW   = acc_width(BITWIDTH, LOG2R);
  localparam int CNTW = (LOG2R > 0) ? LOG2R : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((1 << LOG2R) - 1);
  localparam logic signed [AW:0] RND = (AW + 1)'(round_offset(LOG2R));

  logic signed [AW-1:0]        acc_q, acc_d;
  logic [CNTW-1:0]             cnt_q, cnt_d;
  logic                        overflow_q, overflow_d;
  logic signed [AW:0]          sum_rnd;
  logic signed [OUT_WIDTH-1:0] res;
  logic                        push, pop, full, empty;
  logic [OUT_WIDTH-1:0]        head;

  // One extra bit so the rounding offset cannot overflow the block sum.
  assign sum_rnd = (AW + 1)'(acc_q) + (AW + 1)'(x) + RND;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    if (x_valid) begin
      if (cnt_q == CNT_LAST) begin
        push  = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_q + AW'(x);
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

`ifdef IIR_DECIM_SAT_EN
  localparam logic signed [AW:0] MAXV = {{(AW - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [AW:0] MINV = ~MAXV;

  logic signed [AW:0] avg;
  logic               sat_now;
  logic               sat_q, sat_d;

  assign avg = sum_rnd >>> LOG2R;

  always_comb begin
    sat_now = 1'b0;
    res     = avg[OUT_WIDTH-1:0];
    if (avg > MAXV) begin
      res     = MAXV[OUT_WIDTH-1:0];
      sat_now = 1'b1;
    end else if (avg < MINV) begin
      res     = MINV[OUT_WIDTH-1:0];
      sat_now = 1'b1;
    end
    // Only results actually produced count; a dropped one still flags.
    sat_d = sat_q | (push & sat_now);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_hit = sat_q;
`else
  // Wrap: keep the low OUT_WIDTH bits of the rounded average.
  assign res     = OUT_WIDTH'(sum_rnd >>> LOG2R);
  assign sat_hit = 1'b0;
`endif

  assign pop        = y_ready && !empty;
  assign overflow_d = overflow_q | (push && full && !pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  sample_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .s_tvalid (push),
    .s_tdata  (res),
    .m_tready (y_ready),
    .m_tdata  (head),
    .full     (full),
    .empty    (empty)
  );

  assign y_valid  = !empty;
  assign y        = head;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_iir_decim_out.sv
// tb/tb_iir_decim_out.sv - directed self-checking bench for iir_decim_out
module tb_iir_decim_out;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               x_valid = 1'b0;
  logic signed [31:0] x = '0;
  logic               y_valid;
  logic               y_ready = 1'b1;
  logic signed [15:0] y;
  logic               overflow;
  logic               sat_hit;

  int n_tests = 0;
  int n_fail  = 0;

  iir_decim_out dut (
    .clk      (clk),
    .rst      (rst),
    .x_valid  (x_valid),
    .x        (x),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y        (y),
    .overflow (overflow),
    .sat_hit  (sat_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    x_valid = 1'b1;
    x       = v;
    tick();
    x_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    tick();
    tick();
    check("rst_y_valid", y_valid, 0);
    check("rst_y", y, 0);
    check("rst_overflow", overflow, 0);
    check("rst_sat_hit", sat_hit, 0);
    rst = 1'b1;
    tick();

    // Basic block average with one-cycle latency.
    send(25); send(10); send(25); send(10);
    check("avg18_valid", y_valid, 1);
    check("avg18_y", y, 18);
    tick();
    check("avg18_popped", y_valid, 0);

    // Gaps between samples; negative rounding.
    send(-1); tick(); send(-1); tick(); send(-1); tick(); send(-2);
    check("neg_valid", y_valid, 1);
    check("neg_y", y, -1);
    tick();
    send(-56); send(19); send(28); send(160);
    check("mix_y", y, 38);
    tick();

    // Large block: clamp or wrap depending on build.
    send(40000); send(40000); send(40000); send(40000);
`ifdef IIR_DECIM_SAT_EN
    check("sat_y", y, 32767);
    check("sat_hit", sat_hit, 1);
`else
    check("wrap_y", y, -25536);
    check("wrap_sat_hit", sat_hit, 0);
`endif
    tick();

    // Back-pressure: four blocks buffered, fifth dropped.
    do_reset();
    y_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      for (int s = 0; s < 4; s++) send(4 * k);
      if (k == 4) check("bp_ovf_before", overflow, 0);
    end
    check("bp_overflow", overflow, 1);
    check("bp_hold_y", y, 4);
    check("bp_hold_valid", y_valid, 1);
    y_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("bp_drain%0d", i), y, 4 * i);
      tick();
    end
    check("bp_empty", y_valid, 0);
    check("bp_ovf_sticky", overflow, 1);

    // Full buffer, pop coincides with a new block completing.
    do_reset();
    y_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      for (int s = 0; s < 4; s++) send(4 * k);
    end
    send(20); send(20); send(20);
    y_ready = 1'b1;
    send(20);
    y_ready = 1'b0;
    check("fp_overflow", overflow, 0);
    check("fp_head", y, 8);
    y_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check($sformatf("fp_drain%0d", i), y, 4 * i);
      tick();
    end
    check("fp_empty", y_valid, 0);

    // Reset mid-block discards the partial sum.
    do_reset();
    send(100); send(100);
    rst = 1'b0;
    tick();
    check("mid_rst_valid", y_valid, 0);
    rst = 1'b1;
    send(8); send(8); send(8);
    check("mid_partial_valid", y_valid, 0);
    send(8);
    check("mid_valid", y_valid, 1);
    check("mid_y", y, 8);
    tick();
    check("mid_empty", y_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
